// File: rtl/multiport_memory_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_pkg
// Purpose  : Shared definitions for the multiport memory: controller state
//            encoding, collision-policy constants and a helper that computes
//            the bit offset of one channel inside a packed per-channel bus.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package mem_pkg;

  // Controller states: CLEAR zeroes the array, READY serves traffic.
  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  // Read/write collision policy on the same address in the same cycle.
  localparam bit WRITE_FIRST_C = 1'b1;  // read returns the data being written
  localparam bit READ_FIRST_C  = 1'b0;  // read returns the pre-write content

  // Low bit index of channel idx in a bus packing width-bit fields.
  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage : mem_pkg
`default_nettype wire

// File: rtl/multiport_memory_if.sv
`default_nettype none
// ============================================================================
// Module   : multiport_memory_if
// Purpose  : Bundles the write port, the NUM_RD read channels, the clear
//            request and the status outputs of the multiport memory.
// Ports    : iWriteEnable/iAddress/iDataIn  write port
//            iReadEn/iReadAddress           per-channel read requests (packed)
//            iClear                         one-cycle clear request
//            oDataOut/oValid                per-channel read responses (packed)
//            oBusy                          clear sequence running
//            modport master: traffic source; modport slave: the memory
// Revision : 1.0 - initial release
// ============================================================================
interface multiport_memory_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10,
  parameter int NUM_RD = 2
);

  logic                     iWriteEnable;
  logic [ADDR_W-1:0]        iAddress;
  logic [DATA_W-1:0]        iDataIn;
  logic [NUM_RD-1:0]        iReadEn;
  logic [NUM_RD*ADDR_W-1:0] iReadAddress;
  logic                     iClear;
  logic [NUM_RD*DATA_W-1:0] oDataOut;
  logic [NUM_RD-1:0]        oValid;
  logic                     oBusy;

  modport master (
    output iWriteEnable, iAddress, iDataIn, iReadEn, iReadAddress, iClear,
    input  oDataOut, oValid, oBusy
  );

  modport slave (
    input  iWriteEnable, iAddress, iDataIn, iReadEn, iReadAddress, iClear,
    output oDataOut, oValid, oBusy
  );

endinterface : multiport_memory_if
`default_nettype wire

// File: rtl/multiport_memory_clear_seq.sv
`default_nettype none
// ============================================================================
// Module   : mem_clear_seq
// Purpose  : CLEAR/READY controller. In CLEAR it walks the address counter
//            from 0 to DEPTH-1, issuing one zero-write per cycle, then falls
//            back to READY. A clear request in READY restarts the walk.
// Ports    : Clock, Reset (async, active-low)
//            i_clear_req   clear request, honoured in READY only
//            o_busy        high while in CLEAR
//            o_clear_we    zero-write strobe for the array write port
//            o_clear_addr  address being zeroed this cycle
// Revision : 1.0 - initial release
// ============================================================================
module mem_clear_seq
  import mem_pkg::*;
#(
  parameter int ADDR_W         = 10,
  parameter int DEPTH          = 1024,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              i_clear_req,
  output logic              o_busy,
  output logic              o_clear_we,
  output logic [ADDR_W-1:0] o_clear_addr
);

  localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam state_t            c_RST_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : READY;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_cnt;
  logic [ADDR_W-1:0] w_cnt_nxt;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_state <= c_RST_STATE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      CLEAR: begin
        // The last address is zeroed on this edge; leave CLEAR with it so the
        // sequence lasts exactly DEPTH cycles.
        if (r_cnt == c_LAST_ADDR) begin
          w_state_nxt = READY;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      READY: begin
        if (i_clear_req) begin
          w_state_nxt = CLEAR;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = c_RST_STATE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign o_busy       = (r_state == CLEAR);
  assign o_clear_we   = (r_state == CLEAR);
  assign o_clear_addr = r_cnt;

endmodule : mem_clear_seq
`default_nettype wire

// File: rtl/multiport_memory.sv
`default_nettype none
// ============================================================================
// Module   : multiport_memory
// Purpose  : DEPTH x DATA_W memory with one write port, NUM_RD independent
//            registered read channels (1-cycle latency, one-cycle valid) and
//            a built-in clear sequencer that zeroes the array after reset and
//            on request.
// Ports    : Clock  single rising-edge clock
//            Reset  asynchronous active-low reset
//            bus    multiport_memory_if.slave (write port, read channels,
//                   clear request, read data/valid, busy)
// Revision : 1.0 - initial release
// ============================================================================
module multiport_memory
  import mem_pkg::*;
#(
  parameter int DATA_W         = 8,
  parameter int ADDR_W         = 10,
  parameter int DEPTH          = 1024,
  parameter int NUM_RD         = 2,
  parameter int WRITE_FIRST    = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              Clock,
  input  logic              Reset,
  multiport_memory_if.slave bus
);

  localparam int                c_IDX_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   c_DEPTH_EXT   = (ADDR_W + 1)'(DEPTH);
  localparam bit                c_WRITE_FIRST = (WRITE_FIRST != 0) ? WRITE_FIRST_C : READ_FIRST_C;

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_busy;
  logic              w_ready;
  logic              w_clr_we;
  logic [ADDR_W-1:0] w_clr_addr;
  logic              w_wr_in_range;
  logic              w_user_we;
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [DATA_W-1:0] w_mem_din;

  logic [NUM_RD*DATA_W-1:0] w_dout_all;
  logic [NUM_RD-1:0]        w_valid_all;

  mem_clear_seq #(
    .ADDR_W         (ADDR_W),
    .DEPTH          (DEPTH),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clear_seq (
    .Clock        (Clock),
    .Reset        (Reset),
    .i_clear_req  (bus.iClear),
    .o_busy       (w_busy),
    .o_clear_we   (w_clr_we),
    .o_clear_addr (w_clr_addr)
  );

  assign w_ready = ~w_busy;

  // Range check at full address width plus one bit so DEPTH == 2**ADDR_W fits.
  assign w_wr_in_range = ({1'b0, bus.iAddress} < c_DEPTH_EXT);

  // A clear request wins over a same-cycle user write.
  assign w_user_we  = w_ready & bus.iWriteEnable & w_wr_in_range & ~bus.iClear;
  assign w_mem_we   = w_clr_we | w_user_we;
  assign w_mem_addr = w_clr_we ? w_clr_addr : bus.iAddress;
  assign w_mem_din  = w_clr_we ? '0 : bus.iDataIn;

  // The array itself has no reset; the clear sequencer initialises it.
  always_ff @(posedge Clock) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr[c_IDX_W-1:0]] <= w_mem_din;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] w_raddr;
    logic              w_rd_in_range;
    logic              w_fwd;
    logic [DATA_W-1:0] w_rdata;
    logic [DATA_W-1:0] r_dout;
    logic              r_valid;

    assign w_raddr       = bus.iReadAddress[slice_lo(k, ADDR_W) +: ADDR_W];
    assign w_rd_in_range = ({1'b0, w_raddr} < c_DEPTH_EXT);
    // Write-first bypass: the array is only updated at the edge, so the
    // incoming write data is forwarded directly on an address match.
    assign w_fwd         = c_WRITE_FIRST & w_user_we & (bus.iAddress == w_raddr);

    always_comb begin
      w_rdata = '0;
      if (w_rd_in_range) begin
        w_rdata = w_fwd ? bus.iDataIn : r_mem[w_raddr[c_IDX_W-1:0]];
      end
    end

    always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
        r_dout  <= '0;
        r_valid <= 1'b0;
      end else if (w_ready && bus.iReadEn[k]) begin
        r_dout  <= w_rdata;
        r_valid <= 1'b1;
      end else begin
        r_valid <= 1'b0;
      end
    end

    assign w_dout_all[slice_lo(k, DATA_W) +: DATA_W] = r_dout;
    assign w_valid_all[k]                            = r_valid;
  end

  assign bus.oDataOut = w_dout_all;
  assign bus.oValid   = w_valid_all;
  assign bus.oBusy    = w_busy;

endmodule : multiport_memory
`default_nettype wire

// File: tb/tb_multiport_memory.sv
`default_nettype none
// ============================================================================
// Module   : tb_multiport_memory
// Purpose  : Self-checking bench for multiport_memory. Two instances share one
//            stimulus stream: DUT0 (DEPTH=1024, write-first) and DUT1
//            (DEPTH=1000, read-first). A behavioural model predicts each read
//            response into per-channel queues; a monitor pops and compares
//            whenever a DUT raises oValid, and checks oBusy every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multiport_memory;

  localparam int DW = 8;
  localparam int AW = 10;
  localparam int NR = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Shared stimulus
  logic          s_we   = 1'b0;
  logic [AW-1:0] s_addr = '0;
  logic [DW-1:0] s_din  = '0;
  logic [NR-1:0] s_ren  = '0;
  logic [AW-1:0] s_ra0  = '0;
  logic [AW-1:0] s_ra1  = '0;
  logic          s_clr  = 1'b0;
  bit            mon_en = 1'b0;

  multiport_memory_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus0 ();
  multiport_memory_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus1 ();

  assign bus0.iWriteEnable = s_we;
  assign bus0.iAddress     = s_addr;
  assign bus0.iDataIn      = s_din;
  assign bus0.iReadEn      = s_ren;
  assign bus0.iReadAddress = {s_ra1, s_ra0};
  assign bus0.iClear       = s_clr;
  assign bus1.iWriteEnable = s_we;
  assign bus1.iAddress     = s_addr;
  assign bus1.iDataIn      = s_din;
  assign bus1.iReadEn      = s_ren;
  assign bus1.iReadAddress = {s_ra1, s_ra0};
  assign bus1.iClear       = s_clr;

  multiport_memory #(
    .DATA_W(DW), .ADDR_W(AW), .DEPTH(1024), .NUM_RD(NR),
    .WRITE_FIRST(1), .CLEAR_ON_RESET(1)
  ) dut0 (
    .Clock (clk),
    .Reset (rst_n),
    .bus   (bus0)
  );

  multiport_memory #(
    .DATA_W(DW), .ADDR_W(AW), .DEPTH(1000), .NUM_RD(NR),
    .WRITE_FIRST(0), .CLEAR_ON_RESET(1)
  ) dut1 (
    .Clock (clk),
    .Reset (rst_n),
    .bus   (bus1)
  );

  // ---------------- reference model ----------------
  logic [DW-1:0] mdl_mem [2][1024];
  int            busy_cnt [2];
  logic [DW-1:0] exp_q [4][$];   // index = dut*2 + channel
  int            n_vec = 0;
  int            n_err = 0;

  function automatic int dep(input int d);
    return (d == 0) ? 1024 : 1000;
  endfunction

  function automatic bit wfirst(input int d);
    return (d == 0);
  endfunction

  function automatic logic [AW-1:0] rnd_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r < 7)      return AW'($urandom_range(0, 15));
    else if (r < 9) return AW'($urandom_range(995, 1023));
    else            return AW'($urandom_range(0, 1023));
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Effect of one rising edge on the model, using the inputs present at it.
  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      if (busy_cnt[d] > 0) begin
        busy_cnt[d]--;
      end else begin
        for (int ch = 0; ch < NR; ch++) begin
          logic [AW-1:0] a;
          logic [DW-1:0] e;
          if (s_ren[ch]) begin
            a = (ch == 0) ? s_ra0 : s_ra1;
            if (int'(a) >= dep(d))                                   e = '0;
            else if (wfirst(d) && s_we && !s_clr && s_addr == a)     e = s_din;
            else                                                     e = mdl_mem[d][a];
            exp_q[d*2+ch].push_back(e);
          end
        end
        if (s_clr) begin
          busy_cnt[d] = dep(d);
          for (int i = 0; i < 1024; i++) mdl_mem[d][i] = '0;
        end else if (s_we && int'(s_addr) < dep(d)) begin
          mdl_mem[d][s_addr] = s_din;
        end
      end
    end
  endtask

  task automatic step(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] din,
                      input logic [NR-1:0] ren, input logic [AW-1:0] ra0,
                      input logic [AW-1:0] ra1, input logic clr);
    s_we = we; s_addr = addr; s_din = din; s_ren = ren; s_ra0 = ra0; s_ra1 = ra1; s_clr = clr;
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0, '0, '0, 1'b0);
  endtask

  task automatic apply_reset(input int ncyc);
    rst_n = 1'b0;
    s_we = 1'b0; s_ren = '0; s_clr = 1'b0;
    for (int i = 0; i < 4; i++) exp_q[i].delete();
    busy_cnt[0] = dep(0);
    busy_cnt[1] = dep(1);
    repeat (ncyc) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Count cycles each DUT reports busy, optionally issuing traffic meanwhile.
  task automatic measure_busy(input string tag, input bit with_traffic);
    int c0 = 0;
    int c1 = 0;
    int guard = 0;
    while ((bus0.oBusy || bus1.oBusy) && guard < 1200) begin
      if (bus0.oBusy) c0++;
      if (bus1.oBusy) c1++;
      if (with_traffic)
        step(1'($urandom_range(0, 1)), rnd_addr(), 8'($urandom), 2'b11, rnd_addr(), rnd_addr(), 1'b0);
      else
        idle(1);
      guard++;
    end
    chk({tag, "_busy_len_d0"}, c0, 1024);
    chk({tag, "_busy_len_d1"}, c1, 1000);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      if (mon_en) begin
        chk("rst_valid_d0", 32'(bus0.oValid), 0);
        chk("rst_data_d0",  32'(bus0.oDataOut), 0);
        chk("rst_busy_d0",  32'(bus0.oBusy), 1);
        chk("rst_valid_d1", 32'(bus1.oValid), 0);
        chk("rst_data_d1",  32'(bus1.oDataOut), 0);
        chk("rst_busy_d1",  32'(bus1.oBusy), 1);
      end
    end else if (mon_en) begin
      for (int d = 0; d < 2; d++) begin
        logic [NR-1:0]    v;
        logic [NR*DW-1:0] dat;
        logic             b;
        v   = (d == 0) ? bus0.oValid   : bus1.oValid;
        dat = (d == 0) ? bus0.oDataOut : bus1.oDataOut;
        b   = (d == 0) ? bus0.oBusy    : bus1.oBusy;
        chk($sformatf("busy_d%0d", d), 32'(b), 32'(busy_cnt[d] > 0));
        for (int ch = 0; ch < NR; ch++) begin
          if (v[ch] !== 1'b0) begin
            if (exp_q[d*2+ch].size() == 0) begin
              n_vec++;
              n_err++;
              $display("FAIL spurious_valid_d%0d_ch%0d: got valid=%b with data 0x%0h, expected no response (t=%0t)",
                       d, ch, v[ch], dat[ch*DW +: DW], $time);
            end else begin
              chk($sformatf("rd_d%0d_ch%0d", d, ch), 32'(dat[ch*DW +: DW]),
                  32'(exp_q[d*2+ch].pop_front()));
            end
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    busy_cnt[0] = dep(0);
    busy_cnt[1] = dep(1);
    mon_en = 1'b1;
    apply_reset(3);
    measure_busy("por", 1'b0);

    // Post-clear read of the top address on channel 0.
    step(1'b0, '0, '0, 2'b01, 10'h3FF, '0, 1'b0);
    // Write then dual-channel read of the same address.
    step(1'b1, 10'h010, 8'hA5, 2'b00, '0, '0, 1'b0);
    step(1'b0, '0, '0, 2'b11, 10'h010, 10'h010, 1'b0);
    // Collision: old value 0x11, same-edge write 0x3C while channel 1 reads.
    step(1'b1, 10'd5, 8'h11, 2'b00, '0, '0, 1'b0);
    step(1'b1, 10'd5, 8'h3C, 2'b10, '0, 10'd5, 1'b0);
    step(1'b0, '0, '0, 2'b11, 10'd5, 10'd5, 1'b0);
    // Out-of-range for DUT1, in range for DUT0.
    step(1'b1, 10'd1010, 8'h77, 2'b00, '0, '0, 1'b0);
    step(1'b0, '0, '0, 2'b11, 10'd1010, 10'd999, 1'b0);
    // Clear request with a dropped simultaneous write and a serviced read.
    step(1'b1, 10'd3, 8'h33, 2'b00, '0, '0, 1'b0);
    step(1'b1, 10'd3, 8'hFF, 2'b01, 10'd3, '0, 1'b1);
    measure_busy("clr", 1'b1);
    step(1'b0, '0, '0, 2'b11, 10'd3, 10'h010, 1'b0);
    idle(2);

    // Randomised traffic with frequent collisions.
    for (int i = 0; i < 1500; i++) begin
      logic [AW-1:0] a;
      a = rnd_addr();
      step(1'($urandom_range(0, 1)), a, 8'($urandom), 2'($urandom_range(0, 3)),
           rnd_addr(), ($urandom_range(0, 3) == 0) ? a : rnd_addr(), 1'b0);
    end

    // Reset in the middle of a clear sequence.
    step(1'b0, '0, '0, 2'b00, '0, '0, 1'b1);
    idle(499);
    apply_reset(3);
    measure_busy("rst_mid", 1'b0);
    step(1'b0, '0, '0, 2'b11, 10'd5, 10'h010, 1'b0);
    for (int i = 0; i < 200; i++)
      step(1'($urandom_range(0, 1)), rnd_addr(), 8'($urandom), 2'($urandom_range(0, 3)),
           rnd_addr(), rnd_addr(), 1'b0);

    idle(3);
    for (int i = 0; i < 4; i++) chk($sformatf("queue_drained_%0d", i), exp_q[i].size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_multiport_memory
`default_nettype wire

// File: doc/multiport_memory.md
Name: multiport_memory

Overview:
- Parametrised successor to the single-write / dual-read (channel a/b) memory.
- One write port and NUM_RD independent read channels. Each read channel has a request strobe, a registered output and a valid flag.
- Built-in clear sequencer zeroes the array after reset and on demand.
- Sits between the packet generator/writer and downstream consumers; each consumer owns one read channel.

Parameters:
- DATA_W, 8, data word width
- ADDR_W, 10, address width
- DEPTH, 1024, number of words; must satisfy DEPTH <= 2**ADDR_W
- NUM_RD, 2, number of read channels (>=1)
- WRITE_FIRST, 1, collision policy: 1 = read returns new data, 0 = read returns old data
- CLEAR_ON_RESET, 1, 1 = run clear sequence after reset release, 0 = go straight to READY

Ports:
- Clock  in  1  single clock; all logic on rising edge
- Reset  in  1  asynchronous, active-low reset
- iWriteEnable  in  1  write strobe
- iAddress  in  ADDR_W  write address
- iDataIn  in  DATA_W  write data
- iReadEn  in  NUM_RD  per-channel read request
- iReadAddress  in  NUM_RD*ADDR_W  per-channel read address; channel k occupies bits [k*ADDR_W +: ADDR_W]
- iClear  in  1  one-cycle request to zero the whole array
- oDataOut  out  NUM_RD*DATA_W  per-channel registered read data, packed as for iReadAddress
- oValid  out  NUM_RD  per-channel one-cycle valid pulse
- oBusy  out  1  high while the clear sequence runs

Behaviour:
- Reset low (asynchronous):
  - oDataOut = 0, oValid = 0, clear counter = 0.
  - FSM enters CLEAR if CLEAR_ON_RESET = 1, else READY.
  - oBusy = CLEAR_ON_RESET.
  - Array contents are not reset asynchronously.
- FSM states: CLEAR, READY.
- CLEAR:
  - Each cycle writes 0 to address cnt, then cnt++. oBusy = 1.
  - When cnt = DEPTH-1 is written: go to READY next cycle, oBusy drops the same edge, cnt returns to 0.
  - Clearing takes exactly DEPTH cycles.
  - iWriteEnable, iReadEn and iClear are ignored. oValid = 0; oDataOut holds its value.
- READY:
  - iClear = 1 goes to CLEAR next edge, cnt = 0, oBusy = 1.
  - iClear wins over a simultaneous write; that write is dropped.
  - Same-cycle reads are still serviced.
- Write (READY only): mem[iAddress] <= iDataIn at the rising edge when iWriteEnable = 1 and iAddress < DEPTH. Out-of-range writes are silently dropped.
- Read channel k (READY only):
  - Request: iReadEn[k] = 1 at edge N.
  - Response: oDataOut[k] = mem[iReadAddress[k]] and oValid[k] = 1 after edge N (1-cycle latency).
  - oValid[k] is 0 on any cycle without a request. oDataOut[k] holds its last value when not reading.
- Read address >= DEPTH: data 0 with oValid[k] = 1.
- Channels are fully independent. Any number may read the same address in the same cycle; all return identical data.
- Read/write collision (same address, same edge):
  - WRITE_FIRST = 1: read returns iDataIn.
  - WRITE_FIRST = 0: read returns the pre-write content.
- Back-to-back reads: full throughput, one result per channel per cycle.
- Reset asserted mid-CLEAR or mid-read: immediate return to the reset state. A partially cleared array is cleared again from address 0 on release (if CLEAR_ON_RESET).
- Width rules: no truncation. Addresses are compared at full ADDR_W against DEPTH.

Decomposition:
- Package mem_pkg:
  - FSM state encoding (CLEAR = 1'b0, READY = 1'b1).
  - Collision-policy constants WRITE_FIRST_C / READ_FIRST_C.
  - Helper function for channel slice offsets.
- Sub-module mem_clear_seq:
  - Contains the FSM, the clear counter and oBusy.
  - Outputs clear_we and clear_addr, which are muxed into the write port.
- Read channels are a generate loop in the top module.

Test Plan:
- Reset release, CLEAR_ON_RESET=1, DEPTH=1024 -> oBusy high exactly 1024 cycles; afterwards a read of addr 0x3FF on channel 0 returns 0x00 with oValid pulse.
- Write 0xA5 to addr 0x010, next cycle both channels read 0x010 -> both oDataOut = 0xA5 and both oValid = 1 one cycle after the request.
- Same-edge write 0x3C to addr 5 while channel 1 reads addr 5 (old value 0x11) -> WRITE_FIRST=1 returns 0x3C; WRITE_FIRST=0 returns 0x11.
- DEPTH=1000: write 0x77 to addr 1010, then read 1010 -> write dropped, read returns 0x00 with oValid=1; mem[0..999] unchanged.
- iClear pulse in READY, simultaneous write 0xFF to addr 3 -> write dropped, oBusy high DEPTH cycles; reads issued during CLEAR give oValid=0; afterwards addr 3 reads 0x00.
- Reset low at cycle 500 of the clear sequence, released 3 cycles later -> outputs 0 during reset, oBusy restarts, clear runs the full DEPTH cycles from address 0.
